// File: rtl/mirror_sweep_counter_if.sv
// Bundle of control, status and formula-facing signals for mirror_sweep_counter.
// slave is the counter's view; master is the driver/formula side.
interface mirror_sweep_counter_if #(
  parameter int N_HALF = 10,
  parameter int CNT_W  = 2*N_HALF+1
);
  logic                  start;
  logic                  pause;
  logic                  abort;
  logic                  formula_out;
  logic [2*N_HALF-1:0]   vec;
  logic                  busy;
  logic                  done;
  logic                  result_valid;
  logic [CNT_W-1:0]      sat_count;
  logic                  found;
  logic [2*N_HALF-1:0]   first_wit;
  logic [2*N_HALF-1:0]   last_wit;

  modport master (
    output start, pause, abort, formula_out,
    input  vec, busy, done, result_valid, sat_count, found, first_wit, last_wit
  );

  modport slave (
    input  start, pause, abort, formula_out,
    output vec, busy, done, result_valid, sat_count, found, first_wit, last_wit
  );
endinterface

// File: rtl/mirror_sweep_counter.sv
// Exhaustive sweep of a combinational formula's input space: counts satisfying
// assignments and records the lowest and highest satisfying vector.
module mirror_sweep_counter #(
  parameter int N_HALF = 10,
  parameter int CNT_W  = 2*N_HALF+1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mirror_sweep_counter_if.slave  io
);
  localparam int W = 2*N_HALF;

  typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     vec_q, vec_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;
  logic             found_q, found_d;
  logic [W-1:0]     first_wit_q, first_wit_d;
  logic [W-1:0]     last_wit_q, last_wit_d;
  logic             result_valid_q, result_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      vec_q          <= '0;
      sat_count_q    <= '0;
      found_q        <= 1'b0;
      first_wit_q    <= '0;
      last_wit_q     <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      vec_q          <= vec_d;
      sat_count_q    <= sat_count_d;
      found_q        <= found_d;
      first_wit_q    <= first_wit_d;
      last_wit_q     <= last_wit_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    vec_d          = vec_q;
    sat_count_d    = sat_count_q;
    found_d        = found_q;
    first_wit_d    = first_wit_q;
    last_wit_d     = last_wit_q;
    result_valid_d = result_valid_q;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          vec_d          = '0;
          sat_count_d    = '0;
          found_d        = 1'b0;
          first_wit_d    = '0;
          last_wit_d     = '0;
          result_valid_d = 1'b0;
          state_d        = SWEEP;
        end
      end
      SWEEP: begin
        // abort wins over pause and over the final-vector transition
        if (io.abort) begin
          state_d = IDLE;
        end else if (!io.pause) begin
          if (io.formula_out) begin
            sat_count_d = sat_count_q + CNT_W'(1);
            last_wit_d  = vec_q;
            if (!found_q) begin
              first_wit_d = vec_q;
              found_d     = 1'b1;
            end
          end
          if (&vec_q) state_d = FINISH;
          else        vec_d   = vec_q + W'(1);
        end
      end
      FINISH: begin
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.vec          = vec_q;
  assign io.busy         = (state_q == SWEEP);
  assign io.done         = (state_q == FINISH);
  assign io.result_valid = result_valid_q;
  assign io.sat_count    = sat_count_q;
  assign io.found        = found_q;
  assign io.first_wit    = first_wit_q;
  assign io.last_wit     = last_wit_q;
endmodule

// File: tb/tb_mirror_sweep_counter.sv
// Scoreboard bench for mirror_sweep_counter at N_HALF=2: truth-table formulas,
// random pauses, aborts and mid-sweep resets against a truth-table model.
module tb_mirror_sweep_counter;
  localparam int NH = 2;
  localparam int W  = 2*NH;
  localparam int NV = 1 << W;

  typedef struct {
    int         kind;   // 0 normal, 1 abort, 2 reset
    int         len;
    int         cnt;
    int         fnd;
    int         fw;
    int         lw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NV-1:0] f_tab;
  logic [NV-1:0] mirror_tab;
  exp_t q[$];
  int total = 0;
  int bad   = 0;

  mirror_sweep_counter_if #(.N_HALF(NH)) ifc ();
  mirror_sweep_counter #(.N_HALF(NH)) dut (.clk(clk), .rst_n(rst_n), .io(ifc.slave));

  assign ifc.formula_out = f_tab[ifc.vec];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference: scan the truth table over vectors [0, upto)
  function automatic exp_t model(input logic [NV-1:0] tab, input int upto);
    exp_t e;
    e.kind = 0; e.len = 0; e.cnt = 0; e.fnd = 0; e.fw = 0; e.lw = 0;
    for (int t = 0; t < upto; t++) begin
      if (tab[t]) begin
        if (e.cnt == 0) e.fw = t;
        e.lw = t;
        e.cnt++;
      end
    end
    e.fnd = (e.cnt > 0) ? 1 : 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic begin_sweep(input logic [NV-1:0] tab);
    f_tab = tab;
    step(); ifc.start = 1'b1;
    step(); ifc.start = 1'b0;
  endtask

  task automatic run_normal(input logic [NV-1:0] tab, input int lo, input int hi, input int pct);
    logic mask[$];
    int done_n = 0;
    int c = 1;
    exp_t e;
    while (done_n < NV) begin
      logic p;
      p = ((c >= lo) && (c <= hi)) || ($urandom_range(99) < pct);
      mask.push_back(p);
      if (!p) done_n++;
      c++;
    end
    e = model(tab, NV);
    e.kind = 0;
    e.len = mask.size();
    q.push_back(e);
    begin_sweep(tab);
    foreach (mask[i]) begin
      ifc.pause = mask[i];
      step();
    end
    ifc.pause = 1'b0;
    repeat (4) step();
  endtask

  task automatic run_abort(input logic [NV-1:0] tab, input int k);
    exp_t e;
    e = model(tab, k-1);
    e.kind = 1;
    e.len = k;
    q.push_back(e);
    begin_sweep(tab);
    repeat (k-1) step();
    ifc.abort = 1'b1;
    step();
    ifc.abort = 1'b0;
    repeat (3) step();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vec"}, int'(ifc.vec), 0);
    chk({tag, "_busy"}, int'(ifc.busy), 0);
    chk({tag, "_done"}, int'(ifc.done), 0);
    chk({tag, "_rv"}, int'(ifc.result_valid), 0);
    chk({tag, "_cnt"}, int'(ifc.sat_count), 0);
    chk({tag, "_found"}, int'(ifc.found), 0);
    chk({tag, "_fw"}, int'(ifc.first_wit), 0);
    chk({tag, "_lw"}, int'(ifc.last_wit), 0);
  endtask

  task automatic run_reset(input logic [NV-1:0] tab, input int k);
    exp_t e;
    e = model(tab, 0);
    e.kind = 2;
    e.len = -1;
    q.push_back(e);
    begin_sweep(tab);
    repeat (k-1) step();
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    ifc.start = 1'b1;
    step(); step();
    ifc.start = 1'b0;
    chk("rst_start_ignored", int'(ifc.busy), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", int'(ifc.busy), 0);
  endtask

  // Monitor: closes out each sweep when busy drops
  int  blen = 0;
  logic prev_busy = 1'b0;
  logic rv_pending = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rv_pending) begin
      chk("rv_after_finish", int'(ifc.result_valid), 1);
      rv_pending = 1'b0;
    end
    if (ifc.done && !(prev_busy && !ifc.busy)) begin
      total++; bad++;
      $display("FAIL stray_done actual=1 required=0 t=%0t", $time);
    end
    if (ifc.busy) begin
      blen++;
    end else if (prev_busy) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_sweep_end actual=end required=none t=%0t", $time);
      end else begin
        e = q.pop_front();
        case (e.kind)
          0: begin
            chk("done", int'(ifc.done), 1);
            chk("busy_len", blen, e.len);
            chk("sat_count", int'(ifc.sat_count), e.cnt);
            chk("found", int'(ifc.found), e.fnd);
            chk("first_wit", int'(ifc.first_wit), e.fw);
            chk("last_wit", int'(ifc.last_wit), e.lw);
            chk("vec_final", int'(ifc.vec), NV-1);
            chk("rv_in_finish", int'(ifc.result_valid), 0);
            rv_pending = 1'b1;
          end
          1: begin
            chk("abort_no_done", int'(ifc.done), 0);
            chk("abort_rv", int'(ifc.result_valid), 0);
            chk("abort_len", blen, e.len);
            chk("abort_cnt", int'(ifc.sat_count), e.cnt);
            chk("abort_found", int'(ifc.found), e.fnd);
            chk("abort_fw", int'(ifc.first_wit), e.fw);
            chk("abort_lw", int'(ifc.last_wit), e.lw);
          end
          default: begin
            chk("rst_no_done", int'(ifc.done), 0);
            chk("rst_cnt", int'(ifc.sat_count), 0);
            chk("rst_vec", int'(ifc.vec), 0);
          end
        endcase
      end
      blen = 0;
    end
    prev_busy = ifc.busy;
  end

  initial begin
    logic [31:0] r;
    logic [NV-1:0] tab;
    int kind;
    for (int t = 0; t < NV; t++) begin
      logic [W-1:0] tt;
      tt = W'(t);
      mirror_tab[t] = (tt[NH-1:0] == tt[W-1:NH]);
    end
    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.pause = 1'b0; ifc.abort = 1'b0;
    f_tab = mirror_tab;
    #23;
    check_zero("reset");
    rst_n = 1'b1;

    run_normal(mirror_tab, 0, -1, 0);
    run_normal('0, 0, -1, 0);
    run_normal(mirror_tab, 3, 7, 0);
    run_abort(mirror_tab, 6);
    run_normal(mirror_tab, 0, -1, 0);
    run_reset(mirror_tab, 5);
    run_normal(mirror_tab, 0, -1, 0);
    run_abort(mirror_tab, 16);

    for (int i = 0; i < 14; i++) begin
      r = $urandom;
      tab = (r[31:30] == 2'b00) ? mirror_tab : r[NV-1:0];
      kind = $urandom_range(5);
      if (kind <= 3)      run_normal(tab, 0, -1, 25);
      else if (kind == 4) run_abort(tab, $urandom_range(NV, 1));
      else                run_reset(tab, $urandom_range(NV, 2));
    end

    repeat (5) step();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mirror_sweep_counter.md
Name: mirror_sweep_counter

Overview:
- Sequential evaluation stage placed directly downstream of a combinational mirror-formula instance. The formula output is 1 iff i_k == i_(k+N_HALF) for every k.
- Drives the formula's input vector through every assignment, 0 to 2^(2*N_HALF)-1.
- Consumes the formula's single-bit output. Counts satisfying assignments and captures the first and last satisfying witness.
- Used to check benchmark formulas against their expected model count; for the mirror formula the count must equal 2^N_HALF.

Parameters:
N_HALF, 10, half-width of the formula input vector; the vector is 2*N_HALF bits wide.
CNT_W, 2*N_HALF+1, width of the satisfying-assignment counter; it must hold 2^(2*N_HALF) without overflow.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
pause  input  1  when 1 in SWEEP, freezes vec and all accumulators for that cycle.
abort  input  1  when 1 in SWEEP, sweep is abandoned.
vec  output  2*N_HALF  registered assignment driven to the formula; bit k maps to formula input i_k.
formula_out  input  1  combinational formula result for the current vec.
busy  output  1  1 while in SWEEP.
done  output  1  one-cycle pulse when a sweep completes normally.
result_valid  output  1  1 when sat_count and the witnesses belong to a completed sweep.
sat_count  output  CNT_W  number of assignments with formula_out=1.
found  output  1  1 once at least one satisfying assignment has been seen in the current or last sweep.
first_wit  output  2*N_HALF  lowest satisfying vec.
last_wit  output  2*N_HALF  highest satisfying vec.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - vec, sat_count, first_wit and last_wit are 0.
  - busy, done, result_valid and found are 0.
- States: IDLE, SWEEP, FINISH.
- IDLE, start=1:
  - vec<=0, sat_count<=0, found<=0, first_wit<=0, last_wit<=0, result_valid<=0.
  - Next state SWEEP.
  - start in any other state is ignored.
- SWEEP, each cycle without pause or abort:
  - formula_out is sampled for the current vec; the formula is purely combinational, so there is zero cycles of latency from vec to sample.
  - If formula_out=1: sat_count<=sat_count+1 and last_wit<=vec. If found=0, also first_wit<=vec and found<=1.
  - If vec is all ones, next state is FINISH and vec holds its value. Otherwise vec<=vec+1.
- SWEEP with pause=1: nothing changes and formula_out is ignored.
- SWEEP with abort=1:
  - abort has priority over pause and over the final-vector transition.
  - Next state IDLE; result_valid stays 0.
  - sat_count and the witnesses keep their partial values but are not valid.
- FINISH: lasts one cycle; done=1 and result_valid<=1; next state IDLE.
- IDLE after a completed sweep: results hold until the next start.
- busy is high for exactly the SWEEP cycles, combinationally from state.
- A sweep without pause takes exactly 2^(2*N_HALF) SWEEP cycles followed by 1 FINISH cycle.
- sat_count never wraps; the maximum possible value is 2^(2*N_HALF).
- If rst_n is asserted mid-sweep, every register returns to its reset value immediately; no done pulse is produced.

Test Plan:
- N_HALF=2 with the mirror formula attached, start pulse:
  - busy high for exactly 16 cycles, then done for 1 cycle.
  - sat_count=4, first_wit=4'b0000, last_wit=4'b1111, found=1, result_valid=1.
- N_HALF=2, formula_out tied to 0: sat_count=0, found=0, first_wit=0, last_wit=0, result_valid=1 after 17 cycles.
- N_HALF=2 mirror formula, pause held high for cycles 3-7 of SWEEP: busy lasts 21 cycles and results are identical to the first scenario.
- N_HALF=2 mirror formula, abort on cycle 6 of SWEEP:
  - Returns to IDLE with no done pulse and result_valid=0.
  - A following start gives the full first-scenario results.
- rst_n pulsed low mid-sweep: all outputs are 0 immediately. start is then ignored while rst_n=0; after release, a new sweep gives sat_count=4.
- N_HALF=10 mirror formula (default): done after 1,048,577 cycles with sat_count=1024, first_wit=0, last_wit=20'hFFFFF.
